aibcr3_dcc_intp_ctrl: RTL and testbench
=======================================

# aibcr3_dcc_intp_ctrl

Sequencing controller for the DCC 8-phase interpolator's 3-bit gray-coded phase select. It accepts up/down decisions from the duty-cycle phase detector and steps the interpolator code one position at a time, waiting a programmable settle time after each change. At either end of the range it hands a carry or borrow to the coarse delay stage over a req/ack handshake. It also supports manual code override and reports lock once the loop dithers.

## Interface

Parameters:
- SETTLE_CYC, 8: cycles the code is held after any change before the next decision is accepted; legal 1..15.
- LOCK_REV, 4: consecutive direction reversals needed to assert lock; legal 1..15.
- RST_CODE, 3'd0: binary code loaded at reset.

Ports:
- CLKIN  in  1  controller clock; all state on its rising edge.
- PDb  in  1  asynchronous, active-low reset.
- en  in  1  loop enable; low freezes the code and returns the FSM to IDLE.
- up  in  1  detector request to advance phase by one step.
- dn  in  1  detector request to retard phase by one step.
- man_en  in  1  manual override enable.
- man_code  in  3  binary code applied while man_en is high.
- cry_ack  in  1  coarse stage acknowledge for cry_req or brw_req.
- gray  out  3  registered gray code to the interpolator.
- code  out  3  registered binary code, for debug.
- cry_req  out  1  request to coarse stage to advance one step.
- brw_req  out  1  request to coarse stage to retard one step.
- busy  out  1  high while the FSM is not in IDLE.
- lock  out  1  dither lock indication.

## Operation

- gray is always code ^ (code >> 1), registered from the next-code value. This gives the sequence 000, 001, 011, 010, 110, 111, 101, 100 for codes 0..7.
- FSM states are IDLE, SETTLE and CARRY. busy = (state != IDLE).
- IDLE, with en=1, man_en=0 and up^dn=1:
  - up with code<7: code+1, go to SETTLE.
  - dn with code>0: code-1, go to SETTLE.
  - up with code==7: assert cry_req, go to CARRY, code unchanged.
  - dn with code==0: assert brw_req, go to CARRY, code unchanged.
- IDLE with up&dn=1 or up|dn=0: no action.
- SETTLE: settle counter is loaded with SETTLE_CYC-1 on entry and decrements each cycle. Return to IDLE on the cycle the counter equals 0. up and dn are ignored.
- CARRY: the request is held until cry_ack is sampled high. On that edge the request drops and code wraps: up direction goes to 0, dn direction goes to 7. The FSM then enters SETTLE.
- Only one request is ever active at a time, and a request is never raised outside CARRY.
- Lock tracking:
  - Every accepted step records its direction, including carry and borrow steps at ack.
  - A step opposite to the previous direction increments rev_cnt, saturating at 15.
  - A step in the same direction clears rev_cnt.
  - lock = (rev_cnt >= LOCK_REV).
- Abort (en=0 or man_en=1): the FSM goes to IDLE, cry_req/brw_req go to 0, rev_cnt and lock clear, and the stored direction is invalidated. With en=0 the code holds. With man_en=1 code <= man_code every cycle; man_en has priority over en.
- Reset (PDb low, asynchronous):
  - code = RST_CODE, gray = gray(RST_CODE) (000 for the default).
  - state IDLE, cry_req = brw_req = 0, busy = 0, lock = 0, rev_cnt = 0, direction invalid.
  - A reset mid-CARRY or mid-SETTLE drops all requests immediately.

## Timing

- Decision sampled at edge N in IDLE: code/gray are valid after edge N, and busy rises after edge N.
- SETTLE lasts exactly SETTLE_CYC cycles. busy falls after edge N+SETTLE_CYC.
- The next decision is sampled no earlier than edge N+SETTLE_CYC+1, giving a minimum step interval of SETTLE_CYC+1 cycles.
- Carry: request rises after edge N. cry_ack sampled high at edge M gives req low, code wrapped after M, and busy low after M+SETTLE_CYC.
- cry_ack outside CARRY is ignored. ack high on the same edge the request rises is not honoured; the request stays high at least one cycle.
- Manual: man_code appears on code/gray one edge after sampling. Releasing man_en gives IDLE on the next cycle, with decisions accepted from that edge.
- No combinational input-to-output paths.

## Test plan

- Reset and ramp: reset with RST_CODE=0, SETTLE_CYC=8, then hold up=1. gray steps 000→001→011→010→110→111→101→100, one step every 9 cycles, and busy shows an 8-cycle pulse after each step.
- Carry handshake: at code 7, up=1 raises cry_req. Hold cry_ack=0 for 5 cycles and confirm cry_req stays high with code at 7. Pulse cry_ack; cry_req drops, code=0, gray=000, then SETTLE. Mirror with dn at code 0 and check brw_req and wrap to 7.
- Lock: with LOCK_REV=4, alternate up/dn at each IDLE. lock rises after the 4th reversal. Two same-direction steps clear rev_cnt and drop lock.
- Simultaneous and ignored inputs:
  - up=dn=1 in IDLE gives no change.
  - up pulses during SETTLE are ignored and code is unchanged.
  - cry_ack while IDLE has no effect.
- Override and abort:
  - man_en=1 with man_code=5 gives code=5, gray=111 next cycle. This applies during SETTLE and CARRY, and requests drop on the same edge.
  - en=0 mid-CARRY drops the request and holds the code.
- Async reset: assert PDb low mid-CARRY between clock edges. cry_req, busy and lock go to 0 and gray goes to 000 immediately, without a clock edge.

Source files
------------

// File: rtl/aibcr3_dcc_intp_ctrl_if.sv
// Bus between the DCC interpolator controller, the phase detector,
// the manual-override source and the coarse delay stage.
interface aibcr3_dcc_intp_ctrl_if;
  logic       en;
  logic       up;
  logic       dn;
  logic       man_en;
  logic [2:0] man_code;
  logic       cry_ack;
  logic [2:0] gray;
  logic [2:0] code;
  logic       cry_req;
  logic       brw_req;
  logic       busy;
  logic       lock;

  // Controller side
  modport slave (
    input  en, up, dn, man_en, man_code, cry_ack,
    output gray, code, cry_req, brw_req, busy, lock
  );

  // Detector / coarse stage / override side
  modport master (
    output en, up, dn, man_en, man_code, cry_ack,
    input  gray, code, cry_req, brw_req, busy, lock
  );
endinterface

// File: rtl/aibcr3_dcc_intp_ctrl.sv
// Sequencing controller for the DCC 8-phase interpolator. Steps a 3-bit
// binary code (driven out as gray) one position per accepted detector
// decision, holds it for a settle time, hands carry/borrow to the coarse
// stage over req/ack at the range ends, and flags lock once the loop dithers.
module aibcr3_dcc_intp_ctrl #(
  parameter int         SETTLE_CYC = 8,
  parameter int         LOCK_REV   = 4,
  parameter logic [2:0] RST_CODE   = 3'd0
) (
  input logic                    CLKIN,
  input logic                    PDb,
  aibcr3_dcc_intp_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CARRY  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] LOCK_TH   = 4'(LOCK_REV);

  // Binary to reflected gray conversion.
  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t     state, nxt_state;
  logic [2:0] code, nxt_code;
  logic [3:0] cnt, nxt_cnt;
  logic [3:0] rev_cnt, nxt_rev;
  logic       dir_up, nxt_dir_up;
  logic       dir_vld, nxt_dir_vld;
  logic       cry_req, nxt_cry;
  logic       brw_req, nxt_brw;
  logic       step_en;
  logic       step_up;
  logic       gray_dummy_unused;

  assign gray_dummy_unused = 1'b0;

  // Next-state, next-code and lock-tracking logic.
  always_comb begin
    nxt_state   = state;
    nxt_code    = code;
    nxt_cnt     = cnt;
    nxt_rev     = rev_cnt;
    nxt_dir_up  = dir_up;
    nxt_dir_vld = dir_vld;
    nxt_cry     = cry_req;
    nxt_brw     = brw_req;
    step_en     = 1'b0;
    step_up     = 1'b0;

    if (bus.man_en) begin
      // Manual override wins over enable; abort everything and follow man_code.
      nxt_state   = IDLE;
      nxt_code    = bus.man_code;
      nxt_cry     = 1'b0;
      nxt_brw     = 1'b0;
      nxt_rev     = 4'd0;
      nxt_dir_vld = 1'b0;
    end else if (!bus.en) begin
      // Loop disabled: freeze code, drop any outstanding request.
      nxt_state   = IDLE;
      nxt_cry     = 1'b0;
      nxt_brw     = 1'b0;
      nxt_rev     = 4'd0;
      nxt_dir_vld = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.up ^ bus.dn) begin
            if (bus.up) begin
              if (code != 3'd7) begin
                nxt_code  = code + 3'd1;
                nxt_cnt   = SETTLE_LD;
                nxt_state = SETTLE;
                step_en   = 1'b1;
                step_up   = 1'b1;
              end else begin
                nxt_cry   = 1'b1;
                nxt_state = CARRY;
              end
            end else begin
              if (code != 3'd0) begin
                nxt_code  = code - 3'd1;
                nxt_cnt   = SETTLE_LD;
                nxt_state = SETTLE;
                step_en   = 1'b1;
                step_up   = 1'b0;
              end else begin
                nxt_brw   = 1'b1;
                nxt_state = CARRY;
              end
            end
          end else begin
            nxt_state = IDLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            nxt_state = IDLE;
          end else begin
            nxt_cnt = cnt - 4'd1;
          end
        end
        CARRY: begin
          if (bus.cry_ack) begin
            // Coarse stage took the step; wrap the fine code to the far end.
            nxt_code  = cry_req ? 3'd0 : 3'd7;
            step_en   = 1'b1;
            step_up   = cry_req;
            nxt_cry   = 1'b0;
            nxt_brw   = 1'b0;
            nxt_cnt   = SETTLE_LD;
            nxt_state = SETTLE;
          end else begin
            nxt_state = CARRY;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cry   = 1'b0;
          nxt_brw   = 1'b0;
        end
      endcase

      if (step_en) begin
        if (dir_vld && (dir_up != step_up)) begin
          nxt_rev = (rev_cnt == 4'd15) ? 4'd15 : rev_cnt + 4'd1;
        end else begin
          nxt_rev = 4'd0;
        end
        nxt_dir_up  = step_up;
        nxt_dir_vld = 1'b1;
      end else begin
        nxt_rev = rev_cnt;
      end
    end
  end

  // State and registered outputs; everything is derived from next-values.
  always_ff @(posedge CLKIN or negedge PDb) begin
    if (!PDb) begin
      state    <= IDLE;
      code     <= RST_CODE;
      cnt      <= 4'd0;
      rev_cnt  <= 4'd0;
      dir_up   <= 1'b0;
      dir_vld  <= 1'b0;
      cry_req  <= 1'b0;
      brw_req  <= 1'b0;
      bus.gray <= to_gray(RST_CODE);
      bus.busy <= 1'b0;
      bus.lock <= 1'b0;
    end else begin
      state    <= nxt_state;
      code     <= nxt_code;
      cnt      <= nxt_cnt;
      rev_cnt  <= nxt_rev;
      dir_up   <= nxt_dir_up;
      dir_vld  <= nxt_dir_vld;
      cry_req  <= nxt_cry;
      brw_req  <= nxt_brw;
      bus.gray <= to_gray(nxt_code);
      bus.busy <= (nxt_state != IDLE);
      bus.lock <= (nxt_rev >= LOCK_TH);
    end
  end

  assign bus.code    = code;
  assign bus.cry_req = cry_req;
  assign bus.brw_req = brw_req;

endmodule

// File: tb/tb_aibcr3_dcc_intp_ctrl.sv
// Directed bench for aibcr3_dcc_intp_ctrl with default parameters
// (SETTLE_CYC=8, LOCK_REV=4, RST_CODE=0). Inputs change 1ns after a rising
// edge; outputs are checked at the same point, i.e. after that edge.
module tb_aibcr3_dcc_intp_ctrl;

  logic CLKIN;
  logic PDb;
  int   checks;
  int   errors;

  aibcr3_dcc_intp_ctrl_if bus ();

  aibcr3_dcc_intp_ctrl #(
    .SETTLE_CYC (8),
    .LOCK_REV   (4),
    .RST_CODE   (3'd0)
  ) dut (
    .CLKIN (CLKIN),
    .PDb   (PDb),
    .bus   (bus)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  // Hand-written gray table for codes 0..7.
  logic [2:0] gtab [8];
  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One detector decision, then wait out the settle time back to IDLE.
  task automatic decide(input logic u, input logic d, input logic [2:0] exp_code,
                        input logic exp_lock, input string tag);
    bus.up = u;
    bus.dn = d;
    tick(1);
    bus.up = 1'b0;
    bus.dn = 1'b0;
    chk({tag, "_code"}, 8'(bus.code), 8'(exp_code));
    chk({tag, "_lock"}, 8'(bus.lock), 8'(exp_lock));
    tick(8);
    chk({tag, "_idle"}, 8'(bus.busy), 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    PDb = 1'b0;
    bus.en = 1'b0;
    bus.up = 1'b0;
    bus.dn = 1'b0;
    bus.man_en = 1'b0;
    bus.man_code = 3'd0;
    bus.cry_ack = 1'b0;

    // Reset state
    #3;
    chk("rst_gray", 8'(bus.gray), 8'd0);
    chk("rst_code", 8'(bus.code), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_lock", 8'(bus.lock), 8'd0);
    chk("rst_req", 8'({bus.cry_req, bus.brw_req}), 8'd0);
    #10 PDb = 1'b1;
    tick(2);
    bus.en = 1'b1;

    // Ramp: one step every 9 cycles, busy high for 8 cycles after each step
    bus.up = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk("ramp_code", 8'(bus.code), 8'(i));
      chk("ramp_gray", 8'(bus.gray), 8'(gtab[i]));
      chk("ramp_busy_rise", 8'(bus.busy), 8'd1);
      tick(7);
      chk("ramp_busy_hold", 8'(bus.busy), 8'd1);
      tick(1);
      chk("ramp_busy_fall", 8'(bus.busy), 8'd0);
    end

    // Carry handshake, ack withheld for 5 cycles
    tick(1);
    bus.up = 1'b0;
    chk("cry_rise", 8'(bus.cry_req), 8'd1);
    chk("cry_busy", 8'(bus.busy), 8'd1);
    tick(5);
    chk("cry_hold", 8'(bus.cry_req), 8'd1);
    chk("cry_hold_code", 8'(bus.code), 8'd7);
    chk("cry_no_brw", 8'(bus.brw_req), 8'd0);
    bus.cry_ack = 1'b1;
    tick(1);
    bus.cry_ack = 1'b0;
    chk("cry_drop", 8'(bus.cry_req), 8'd0);
    chk("cry_wrap_code", 8'(bus.code), 8'd0);
    chk("cry_wrap_gray", 8'(bus.gray), 8'd0);
    chk("cry_settle", 8'(bus.busy), 8'd1);
    tick(7);
    chk("cry_settle_hold", 8'(bus.busy), 8'd1);
    tick(1);
    chk("cry_settle_end", 8'(bus.busy), 8'd0);

    // Borrow with ack already high when the request rises: not honoured then
    bus.dn = 1'b1;
    bus.cry_ack = 1'b1;
    tick(1);
    bus.dn = 1'b0;
    chk("brw_rise", 8'(bus.brw_req), 8'd1);
    chk("brw_no_cry", 8'(bus.cry_req), 8'd0);
    chk("brw_code", 8'(bus.code), 8'd0);
    tick(1);
    bus.cry_ack = 1'b0;
    chk("brw_drop", 8'(bus.brw_req), 8'd0);
    chk("brw_wrap_code", 8'(bus.code), 8'd7);
    chk("brw_wrap_gray", 8'(bus.gray), 8'b100);
    tick(8);
    chk("brw_settle_end", 8'(bus.busy), 8'd0);

    // Lock: last dir dn. dn clears, then 4 reversals assert lock, dn clears
    decide(1'b0, 1'b1, 3'd6, 1'b0, "lk0");
    decide(1'b1, 1'b0, 3'd7, 1'b0, "lk1");
    decide(1'b0, 1'b1, 3'd6, 1'b0, "lk2");
    decide(1'b1, 1'b0, 3'd7, 1'b0, "lk3");
    decide(1'b0, 1'b1, 3'd6, 1'b1, "lk4");
    decide(1'b0, 1'b1, 3'd5, 1'b0, "lk_clr");

    // up and dn together in IDLE: no action
    bus.up = 1'b1;
    bus.dn = 1'b1;
    tick(2);
    bus.up = 1'b0;
    bus.dn = 1'b0;
    chk("both_code", 8'(bus.code), 8'd5);
    chk("both_busy", 8'(bus.busy), 8'd0);

    // up pulses during SETTLE are ignored
    bus.up = 1'b1;
    tick(1);
    chk("settle_step", 8'(bus.code), 8'd6);
    tick(3);
    bus.up = 1'b0;
    tick(5);
    chk("settle_ign_code", 8'(bus.code), 8'd6);
    chk("settle_ign_busy", 8'(bus.busy), 8'd0);

    // cry_ack in IDLE does nothing
    bus.cry_ack = 1'b1;
    tick(2);
    bus.cry_ack = 1'b0;
    chk("ack_idle_code", 8'(bus.code), 8'd6);
    chk("ack_idle_req", 8'({bus.cry_req, bus.brw_req, bus.busy}), 8'd0);

    // Manual override during SETTLE
    bus.up = 1'b1;
    tick(1);
    bus.up = 1'b0;
    chk("man_pre", 8'(bus.code), 8'd7);
    bus.man_en = 1'b1;
    bus.man_code = 3'd5;
    tick(1);
    chk("man_s_code", 8'(bus.code), 8'd5);
    chk("man_s_gray", 8'(bus.gray), 8'b111);
    chk("man_s_busy", 8'(bus.busy), 8'd0);
    // Release: decision accepted on the very next edge
    bus.man_en = 1'b0;
    bus.up = 1'b1;
    tick(1);
    bus.up = 1'b0;
    chk("man_rel_code", 8'(bus.code), 8'd6);
    tick(8);
    decide(1'b1, 1'b0, 3'd7, 1'b0, "to7a");

    // Manual override during CARRY drops the request on the same edge
    bus.up = 1'b1;
    tick(1);
    bus.up = 1'b0;
    chk("man_c_req", 8'(bus.cry_req), 8'd1);
    bus.man_en = 1'b1;
    tick(1);
    bus.man_en = 1'b0;
    chk("man_c_drop", 8'(bus.cry_req), 8'd0);
    chk("man_c_code", 8'(bus.code), 8'd5);
    chk("man_c_gray", 8'(bus.gray), 8'b111);
    chk("man_c_busy", 8'(bus.busy), 8'd0);
    tick(1);
    decide(1'b1, 1'b0, 3'd6, 1'b0, "to6");
    decide(1'b1, 1'b0, 3'd7, 1'b0, "to7b");

    // en=0 during CARRY drops the request and holds the code
    bus.up = 1'b1;
    tick(1);
    bus.up = 1'b0;
    chk("en_c_req", 8'(bus.cry_req), 8'd1);
    bus.en = 1'b0;
    tick(1);
    chk("en_c_drop", 8'(bus.cry_req), 8'd0);
    chk("en_c_code", 8'(bus.code), 8'd7);
    chk("en_c_busy", 8'(bus.busy), 8'd0);
    bus.en = 1'b1;
    tick(1);

    // Async reset mid-CARRY, between edges
    bus.up = 1'b1;
    tick(1);
    bus.up = 1'b0;
    chk("ar_req", 8'(bus.cry_req), 8'd1);
    #2 PDb = 1'b0;
    #1;
    chk("ar_cry", 8'(bus.cry_req), 8'd0);
    chk("ar_busy", 8'(bus.busy), 8'd0);
    chk("ar_lock", 8'(bus.lock), 8'd0);
    chk("ar_gray", 8'(bus.gray), 8'd0);
    chk("ar_code", 8'(bus.code), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
